// File: rtl/arbiter_types_pkg.sv
// arbiter_types_pkg: shared state/client enums and default widths for the cache arbiter.
package arbiter_types_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {CLIENT_I, CLIENT_D} arb_client_t;
endpackage

// File: rtl/rr_grant2.sv
// rr_grant2: two-requester round-robin grant; last_grant advances only when update is high.
module rr_grant2
  import arbiter_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        req_d,
  input  logic        update,
  output logic        valid,
  output arb_client_t grant
);
  arb_client_t last_grant;
  assign valid = req_i | req_d;
  always_comb grant = (req_i && req_d) ? (last_grant == CLIENT_D ? CLIENT_I : CLIENT_D) :
                      (req_i ? CLIENT_I : CLIENT_D);
  always_ff @(posedge clk) begin
    if (rst) last_grant <= CLIENT_D;
    else if (update && valid) last_grant <= grant;
  end
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: arbitrates I-cache fills and D-cache fills/write-backs onto one physical memory port.
module cache_arbiter
  import arbiter_types_pkg::arb_state_t, arbiter_types_pkg::arb_client_t,
         arbiter_types_pkg::IDLE, arbiter_types_pkg::SERVE_I, arbiter_types_pkg::SERVE_D,
         arbiter_types_pkg::CLIENT_I, arbiter_types_pkg::CLIENT_D;
#(
  parameter int ADDR_W = arbiter_types_pkg::ADDR_W,
  parameter int LINE_W = arbiter_types_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);
  arb_state_t        state, next_state;
  arb_client_t       grant;
  logic              grant_valid;
  logic              take;
  logic              done;
  logic [ADDR_W-1:0] req_addr;
  assign take = (state == IDLE) && grant_valid;
  assign done = (state != IDLE) && mem_resp;
  rr_grant2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req_i  (i_pmem_read),
    .req_d  (d_pmem_read | d_pmem_write),
    .update (take),
    .valid  (grant_valid),
    .grant  (grant)
  );
  always_comb begin
    req_addr   = (grant == CLIENT_D ? d_pmem_address : i_pmem_address) & LINE_MASK;
    next_state = take ? (grant == CLIENT_D ? SERVE_D : SERVE_I) : (done ? IDLE : state);
  end
  // A D-side write wins over a simultaneous D-side read for the same grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      state <= next_state;
      if (take) begin
        mem_read    <= (grant == CLIENT_I) || !d_pmem_write;
        mem_write   <= (grant == CLIENT_D) && d_pmem_write;
        mem_address <= req_addr;
        mem_wdata   <= grant == CLIENT_D ? d_pmem_wdata : '0;
      end else if (done) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end
    end
  end
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign i_pmem_resp  = mem_resp && (state == SERVE_I);
  assign d_pmem_resp  = mem_resp && (state == SERVE_D);
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: scoreboard bench; stimulus queues expected memory requests and client responses, monitors compare.
module tb_cache_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_pmem_read = 1'b0;
  logic [31:0]  i_pmem_address = '0;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read = 1'b0;
  logic         d_pmem_write = 1'b0;
  logic [31:0]  d_pmem_address = '0;
  logic [255:0] d_pmem_wdata = '0;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_resp = 1'b0;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct {logic rd; logic wr; logic [31:0] addr; logic [255:0] wdata;} mem_t;
  typedef struct {logic is_d; logic [255:0] data;} rsp_t;
  mem_t mq[$];
  rsp_t rq[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (i_pmem_resp || d_pmem_resp) begin
      if (rq.size() == 0) chk("unexpected_resp", {254'd0, i_pmem_resp, d_pmem_resp}, '0);
      else begin
        e = rq.pop_front();
        chk("resp_client", {254'd0, i_pmem_resp, d_pmem_resp}, e.is_d ? 256'd1 : 256'd2);
        chk("resp_data", e.is_d ? d_pmem_rdata : i_pmem_rdata, e.data);
      end
    end
  end

  logic act_prev = 1'b0;
  mem_t cur;
  always @(negedge clk) begin
    if (mem_read && mem_write) chk("rd_wr_exclusive", 256'd1, 256'd0);
    if ((mem_read || mem_write) && !act_prev) begin
      if (mq.size() == 0) chk("unexpected_mem_req", 256'd1, 256'd0);
      else begin
        cur = mq.pop_front();
        chk("req_read", {255'd0, mem_read}, {255'd0, cur.rd});
        chk("req_write", {255'd0, mem_write}, {255'd0, cur.wr});
        chk("req_addr", {224'd0, mem_address}, {224'd0, cur.addr});
        chk("req_wdata", mem_wdata, cur.wdata);
      end
    end else if (mem_read || mem_write) begin
      chk("hold_ctl", {254'd0, mem_read, mem_write}, {254'd0, cur.rd, cur.wr});
      chk("hold_addr", {224'd0, mem_address}, {224'd0, cur.addr});
      chk("hold_wdata", mem_wdata, cur.wdata);
    end
    act_prev = mem_read || mem_write;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_active;
    int n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      tick();
      n++;
    end
    chk("grant_latency", 256'(n), 256'd1);
  endtask

  task automatic mem_txn(input int lat, input logic [255:0] rd);
    wait_active();
    repeat (lat) tick();
    mem_rdata = rd;
    mem_resp  = 1'b1;
    tick();
    mem_resp  = 1'b0;
  endtask

  localparam logic [255:0] A1 = {8{32'h1111_0001}};
  localparam logic [255:0] A2 = {8{32'h2222_0002}};
  localparam logic [255:0] A3 = {8{32'h3333_0003}};
  localparam logic [255:0] B  = {8{32'hB0B0_1234}};
  localparam logic [255:0] C  = {8{32'hC0DE_0041}};
  localparam logic [255:0] D  = {8{32'hD00D_0ABC}};
  localparam logic [255:0] E  = {8{32'hE0E0_3000}};
  localparam logic [255:0] W  = {32{8'hAA}};
  localparam logic [255:0] W2 = {16{16'h5A5A}};
  localparam logic [255:0] W3 = {8{32'hDEAD_BEEF}};

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_read", {255'd0, mem_read}, '0);
    chk("rst_mem_write", {255'd0, mem_write}, '0);
    chk("rst_mem_address", {224'd0, mem_address}, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_resps", {254'd0, i_pmem_resp, d_pmem_resp}, '0);
    tick();
    // tie held for three rounds: reset last_grant=D so order is I, D, I
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_201F;
    d_pmem_read = 1'b1; d_pmem_address = 32'h4000_0005;
    mq.push_back('{1'b1, 1'b0, 32'h0000_2000, '0});
    mq.push_back('{1'b1, 1'b0, 32'h4000_0000, '0});
    mq.push_back('{1'b1, 1'b0, 32'h0000_2000, '0});
    rq.push_back('{1'b0, A1});
    rq.push_back('{1'b1, A2});
    rq.push_back('{1'b0, A3});
    mem_txn(2, A1);
    mem_txn(3, A2);
    mem_txn(1, A3);
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    tick();
    // I only
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_1234;
    mq.push_back('{1'b1, 1'b0, 32'h0000_1220, '0});
    rq.push_back('{1'b0, B});
    mem_txn(5, B);
    i_pmem_read = 1'b0;
    @(negedge clk);
    chk("idle_after_i_read", {255'd0, mem_read}, '0);
    tick();
    // D write-back
    d_pmem_write = 1'b1; d_pmem_address = 32'h8000_0040; d_pmem_wdata = W;
    mq.push_back('{1'b0, 1'b1, 32'h8000_0040, W});
    rq.push_back('{1'b1, C});
    mem_txn(4, C);
    d_pmem_write = 1'b0;
    @(negedge clk);
    chk("idle_after_wb", {254'd0, mem_read, mem_write}, '0);
    tick();
    // D read and write together: write only
    d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    d_pmem_address = 32'h0000_0ABC; d_pmem_wdata = W2;
    mq.push_back('{1'b0, 1'b1, 32'h0000_0AA0, W2});
    rq.push_back('{1'b1, D});
    mem_txn(3, D);
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    tick();
    // reset in third cycle of SERVE_D
    d_pmem_write = 1'b1; d_pmem_address = 32'h1234_5678; d_pmem_wdata = W3;
    mq.push_back('{1'b0, 1'b1, 32'h1234_5660, W3});
    wait_active();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; d_pmem_write = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", {254'd0, mem_read, mem_write}, '0);
    chk("midrst_addr", {224'd0, mem_address}, '0);
    chk("midrst_wdata", mem_wdata, '0);
    tick();
    mem_resp = 1'b1; mem_rdata = W3;
    @(negedge clk);
    chk("stray_resp", {254'd0, i_pmem_resp, d_pmem_resp}, '0);
    tick();
    mem_resp = 1'b0;
    tick();
    // spurious mem_resp in IDLE
    mem_resp = 1'b1;
    @(negedge clk);
    chk("spurious_resp", {254'd0, i_pmem_resp, d_pmem_resp}, '0);
    chk("spurious_ctl", {254'd0, mem_read, mem_write}, '0);
    tick();
    mem_resp = 1'b0;
    // still IDLE and last_grant back at D: a tie grants I next edge
    i_pmem_read = 1'b1; i_pmem_address = 32'h0000_3007;
    d_pmem_read = 1'b1; d_pmem_address = 32'h0000_5000;
    mq.push_back('{1'b1, 1'b0, 32'h0000_3000, '0});
    rq.push_back('{1'b0, E});
    mem_txn(2, E);
    i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    tick();
    tick();
    chk("mem_queue_empty", 256'(mq.size()), '0);
    chk("resp_queue_empty", 256'(rq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
